// File: rtl/simd2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd2_pkg : shared defaults and FSM state type for min_reduce_stream|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package simd2_pkg;

    localparam int W_DEF     = 16;
    localparam int LANES_DEF = 4;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : simd2_pkg
`default_nettype wire

// File: rtl/min_reduce_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | min_reduce_stream_if : input beat stream and result handshake      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface min_reduce_stream_if
    import simd2_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int IDX_W = IDX_W_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_min;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_idx, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_idx, out_ovf
    );
endinterface : min_reduce_stream_if
`default_nettype wire

// File: rtl/min_reduce_stream_min_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | min_tree : combinational unsigned minimum across lanes, lower lane |
// |            wins on ties. Rev 1.0                                   |
// +--------------------------------------------------------------------+
module min_tree #(
    parameter int W      = 16,
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  wire logic [LANES*W-1:0] data_i,
    output logic      [W-1:0]       min_o,
    output logic      [LANE_W-1:0]  lane_o
);

    // Strict less-than while scanning upward keeps the lowest lane on ties.
    always_comb begin
        min_o  = data_i[W-1:0];
        lane_o = '0;
        for (int k = 1; k < LANES; k++) begin
            if (data_i[k*W +: W] < min_o) begin
                min_o  = data_i[k*W +: W];
                lane_o = LANE_W'(k);
            end
        end
    end

endmodule : min_tree
`default_nettype wire

// File: rtl/min_reduce_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | min_reduce_stream : streaming min/argmin reduction over multi-lane |
// |                     beats with index-overflow termination. Rev 1.0 |
// +--------------------------------------------------------------------+
module min_reduce_stream
    import simd2_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input wire logic          clk,
    input wire logic          rst_n,
    min_reduce_stream_if.slave bus
);

    localparam int c_LANE_SH = $clog2(LANES);
    localparam int c_LANE_W  = (LANES > 1) ? c_LANE_SH : 1;
    localparam int c_BCNT_W  = IDX_W - c_LANE_SH;
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = '1;

    state_t                state_q,    state_d;
    logic [c_BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [W-1:0]          min_q,      min_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic                  ovf_q,      ovf_d;

    logic [W-1:0]          w_beat_min;
    logic [c_LANE_W-1:0]   w_beat_lane;
    logic [IDX_W-1:0]      w_beat_idx;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_force_last;
    logic                  w_last;
    logic                  w_take;

    min_tree #(
        .W      (W),
        .LANES  (LANES),
        .LANE_W (c_LANE_W)
    ) u_min_tree (
        .data_i (bus.in_data),
        .min_o  (w_beat_min),
        .lane_o (w_beat_lane)
    );

    assign w_in_ready   = (state_q != HOLD);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_beat_idx   = (IDX_W'(beat_cnt_q) << c_LANE_SH) | IDX_W'(w_beat_lane);
    // The final beat that still fits the index space closes the reduction.
    assign w_force_last = (beat_cnt_q == c_BCNT_LAST);
    assign w_last       = bus.in_last || w_force_last;
    assign w_take       = (state_q == IDLE) || (w_beat_min < min_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            min_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            min_q      <= min_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        min_d      = min_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    if (w_take) begin
                        min_d = w_beat_min;
                        idx_d = w_beat_idx;
                    end
                    if (w_last) begin
                        state_d    = HOLD;
                        beat_cnt_d = '0;
                        ovf_d      = !bus.in_last;
                    end else begin
                        state_d    = ACCUM;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_min   = min_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_ovf   = ovf_q;

endmodule : min_reduce_stream
`default_nettype wire

// File: tb/tb_min_reduce_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_min_reduce_stream : directed self-checking bench                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_min_reduce_stream;

    localparam int W     = 16;
    localparam int LANES = 4;
    localparam int IDX_W = 8;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    min_reduce_stream_if #(.W(W), .LANES(LANES), .IDX_W(IDX_W)) bus ();

    min_reduce_stream #(.W(W), .LANES(LANES), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] a0, input logic [15:0] a1,
                                         input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Present a beat from a falling edge and return right after the accepting rising edge.
    task automatic send(input logic [63:0] d, input logic last);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] m, input logic [7:0] idx,
                              input logic ovf);
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_min"},   {48'd0, bus.out_min},   {48'd0, m});
        chk({tag, "_idx"},   {56'd0, bus.out_idx},   {56'd0, idx});
        chk({tag, "_ovf"},   {63'd0, bus.out_ovf},   {63'd0, ovf});
        chk({tag, "_inrdy"}, {63'd0, bus.in_ready},  64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_min",   {48'd0, bus.out_min},   64'd0);
        chk("rst_idx",   {56'd0, bus.out_idx},   64'd0);
        chk("rst_ovf",   {63'd0, bus.out_ovf},   64'd0);
        chk("rst_inrdy", {63'd0, bus.in_ready},  64'd1);
        rst_n = 1'b1;

        // Single beat, tie between lanes 1 and 3
        send(pack(16'd5, 16'd3, 16'd9, 16'd3), 1'b1);
        idle();
        chk_result("single", 16'd3, 8'd1, 1'b0);
        @(negedge clk);
        chk("single_done_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("single_done_inrdy", {63'd0, bus.in_ready},  64'd1);

        // Three beats, tie on 6 keeps earliest index, consumer stalls
        bus.out_ready = 1'b0;
        send(pack(16'd10, 16'd20, 16'd30, 16'd40), 1'b0);
        send(pack(16'd7, 16'd8, 16'd9, 16'd6), 1'b0);
        send(pack(16'd6, 16'd100, 16'd200, 16'd300), 1'b1);
        idle();
        chk_result("multi", 16'd6, 8'd7, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = pack(16'd1, 16'd1, 16'd1, 16'd1);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_result("stall", 16'd6, 8'd7, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("stall_done_inrdy", {63'd0, bus.in_ready},  64'd1);
        chk("stall_done_min",   {48'd0, bus.out_min},   64'd6);

        // Reset in the middle of a reduction
        send(pack(16'd50, 16'd60, 16'd70, 16'd80), 1'b0);
        send(pack(16'd40, 16'd41, 16'd42, 16'd43), 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_min",   {48'd0, bus.out_min},   64'd0);
        chk("mid_rst_inrdy", {63'd0, bus.in_ready},  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        send(pack(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
        idle();
        chk_result("post_rst", 16'd1, 8'd0, 1'b0);

        // Index overflow: 64 beats, in_last never set
        for (int i = 0; i < 63; i++) begin
            send(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0);
        end
        idle();
        chk("ovf63_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ovf63_inrdy", {63'd0, bus.in_ready},  64'd1);
        send(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0);
        idle();
        chk_result("ovf", 16'hFFFF, 8'd0, 1'b1);
        @(negedge clk);
        chk("ovf_done_valid", {63'd0, bus.out_valid}, 64'd0);

        // in_valid gaps inside a reduction
        send(pack(16'd4, 16'd4, 16'd4, 16'd4), 1'b0);
        idle();
        bus.in_data = pack(16'd0, 16'd0, 16'd0, 16'd0);
        bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_last = 1'b0;
        chk("gap_valid", {63'd0, bus.out_valid}, 64'd0);
        send(pack(16'd2, 16'd9, 16'd9, 16'd2), 1'b1);
        idle();
        chk_result("gap", 16'd2, 8'd4, 1'b0);
        @(negedge clk);
        chk("gap_done_valid", {63'd0, bus.out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_min_reduce_stream
`default_nettype wire
